// File: rtl/acq_trig_ctrl.sv
// rtl/acq_trig_ctrl.sv - acquisition trigger controller writing ADC samples to sample memory
//
// Purpose: arms on a cpu_flag rising edge, waits for an immediate or external
// trigger, waits a programmable delay, then writes N consecutive ADC samples
// to addresses 0..N-1 and reports completion until cpu_flag is released.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   cpu_flag         arm request level (rising edge arms, falling edge aborts pre-capture)
//   ext_trig         external trigger, synchronous to clk
//   trig_src         0 = fire on arm, 1 = fire on ext_trig rising edge
//   trig_delay       post-trigger delay in cycles
//   num_samples      capture length (0 -> 1, clamped to 2^ADDR_W)
//   adc_data         ADC sample, valid every cycle
//   bram_we/addr/din sample memory write port
//   busy             high in ARMED, DELAY, CAPTURE
//   write_finished   high in DONE

module acq_trig_ctrl #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_flag,
    input  logic              ext_trig,
    input  logic              trig_src,
    input  logic [15:0]       trig_delay,
    input  logic [ADDR_W:0]   num_samples,
    input  logic [DATA_W-1:0] adc_data,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              write_finished
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   MAX_N    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_N    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              cpu_flag_q, cpu_flag_d;
    logic              ext_trig_q, ext_trig_d;
    logic              src_q, src_d;
    logic [15:0]       delay_q, delay_d;
    logic [15:0]       dly_cnt_q, dly_cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] adc_q, adc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              wf_q, wf_d;

    logic              cpu_rise, cpu_fall, ext_rise;
    logic [ADDR_W:0]   n_m1;

    always_comb begin
        cpu_rise   = cpu_flag & ~cpu_flag_q;
        cpu_fall   = ~cpu_flag & cpu_flag_q;
        ext_rise   = ext_trig & ~ext_trig_q;
        n_m1       = num_samples - ONE_N;

        state_d    = state_q;
        cpu_flag_d = cpu_flag;
        ext_trig_d = ext_trig;
        src_d      = src_q;
        delay_d    = delay_q;
        dly_cnt_d  = dly_cnt_q;
        last_d     = last_q;
        adc_d      = adc_data;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_rise) begin
                    src_d   = trig_src;
                    delay_d = trig_delay;
                    // Store the last address (N-1) so the capture loop needs a single compare.
                    if (num_samples == '0) begin
                        last_d = '0;
                    end else if (num_samples >= MAX_N) begin
                        last_d = '1;
                    end else begin
                        last_d = n_m1[ADDR_W-1:0];
                    end
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (cpu_fall) begin
                    state_d = S_IDLE;
                end else if (!src_q || ext_rise) begin
                    dly_cnt_d = delay_q;
                    state_d   = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cpu_fall) begin
                    state_d = S_IDLE;
                end else if (dly_cnt_q == 16'd0) begin
                    // First write is issued on entry so bram_we is high for every CAPTURE cycle.
                    state_d = S_CAPTURE;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = adc_q;
                end else begin
                    dly_cnt_d = dly_cnt_q - 16'd1;
                end
            end
            S_CAPTURE: begin
                if (addr_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    din_d  = adc_q;
                end
            end
            S_DONE: begin
                if (!cpu_flag) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE);
        wf_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cpu_flag_q <= 1'b0;
            ext_trig_q <= 1'b0;
            src_q      <= 1'b0;
            delay_q    <= '0;
            dly_cnt_q  <= '0;
            last_q     <= '0;
            adc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            wf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_flag_q <= cpu_flag_d;
            ext_trig_q <= ext_trig_d;
            src_q      <= src_d;
            delay_q    <= delay_d;
            dly_cnt_q  <= dly_cnt_d;
            last_q     <= last_d;
            adc_q      <= adc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            wf_q       <= wf_d;
        end
    end

    assign bram_we        = we_q;
    assign bram_addr      = addr_q;
    assign bram_din       = din_q;
    assign busy           = busy_q;
    assign write_finished = wf_q;

endmodule

// File: tb/tb_acq_trig_ctrl.sv
// tb/tb_acq_trig_ctrl.sv - scoreboard testbench for acq_trig_ctrl

module tb_acq_trig_ctrl;

    localparam int AW   = 6;
    localparam int DW   = 14;
    localparam int NMAX = 1 << AW;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_flag;
    logic          ext_trig;
    logic          trig_src;
    logic [15:0]   trig_delay;
    logic [AW:0]   num_samples;
    logic [DW-1:0] adc_data;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          busy;
    logic          write_finished;

    acq_trig_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_flag       (cpu_flag),
        .ext_trig       (ext_trig),
        .trig_src       (trig_src),
        .trig_delay     (trig_delay),
        .num_samples    (num_samples),
        .adc_data       (adc_data),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .busy           (busy),
        .write_finished (write_finished)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen; at a falling edge it names
    // the cycle whose outputs are visible, and inputs driven then land on edge cyc+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int adc_mem [MAXC];

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  errors   = 0;
    int  checks   = 0;
    int  wr_count = 0;

    always @(negedge clk) adc_data = DW'(adc_mem[(cyc + 1) % MAXC]);

    // Monitor: every write the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (bram_we === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: cyc=%0d addr=%0d data=%0d, no write expected",
                         cyc, bram_addr, bram_din);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || e.a != int'(bram_addr) || e.d != int'(bram_din)) begin
                    errors++;
                    $display("FAIL write: got cyc=%0d addr=%0d data=%0d, expected cyc=%0d addr=%0d data=%0d",
                             cyc, bram_addr, bram_din, e.c, e.a, e.d);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_write: no write at cyc=%0d, expected addr=%0d data=%0d at cyc=%0d",
                     cyc, e.a, e.d, e.c);
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic int n_eff(input int n);
        if (n == 0) return 1;
        if (n > NMAX) return NMAX;
        return n;
    endfunction

    task automatic push_writes(input int c, input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.c = c + k;
            w.a = k;
            w.d = adc_mem[(c + k - 1) % MAXC] % (1 << DW);
            exp_q.push_back(w);
        end
    endtask

    // One full capture; expected timing follows directly from the trigger rules:
    // DELAY entered at edge d0, capture starts at d0+delay+1, N writes back to back.
    task automatic run_capture(input int src, input int dly, input int nsamp, input int ext_wait,
                               input int ext_pre_high, input int drop_cap, input int hold_done);
        int a, d0, c, n, w0;
        ext_trig = (ext_pre_high != 0);
        step();
        trig_src    = src[0];
        trig_delay  = 16'(dly);
        num_samples = (AW+1)'(nsamp);
        cpu_flag    = 1'b1;
        a = cyc + 1;
        n = n_eff(nsamp);
        step();
        // Configuration changes after arming must not matter.
        trig_src    = 1'($urandom);
        trig_delay  = 16'($urandom);
        num_samples = (AW+1)'($urandom);
        chk("busy_armed", int'(busy), 1);
        if (src == 0) begin
            d0 = a + 1;
        end else begin
            w0 = wr_count;
            repeat (ext_wait) step();
            chk("armed_wait_busy", int'(busy), 1);
            chk("armed_no_write", wr_count, w0);
            if (ext_pre_high != 0) begin
                ext_trig = 1'b0;
                step();
            end
            ext_trig = 1'b1;
            d0 = cyc + 1;
            step();
            ext_trig = 1'b0;
        end
        c = d0 + dly + 1;
        push_writes(c, n);
        if (drop_cap != 0 && n >= 3) begin
            wait_cyc(c + 1);
            cpu_flag = 1'b0;
        end
        wait_cyc(c + n - 1);
        chk("wf_before_done", int'(write_finished), 0);
        chk("busy_last_write", int'(busy), 1);
        wait_cyc(c + n);
        chk("wf_done", int'(write_finished), 1);
        chk("busy_done", int'(busy), 0);
        if (cpu_flag == 1'b0) begin
            step();
            chk("wf_idle_after_drop", int'(write_finished), 0);
        end else begin
            repeat (hold_done) begin
                step();
                chk("wf_hold", int'(write_finished), 1);
            end
            cpu_flag = 1'b0;
            step();
            chk("wf_idle", int'(write_finished), 0);
        end
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic run_abort(input int src);
        int a, w0;
        step();
        trig_src    = src[0];
        trig_delay  = 16'd20;
        num_samples = (AW+1)'(8);
        cpu_flag    = 1'b1;
        a  = cyc + 1;
        w0 = wr_count;
        wait_cyc(a + 4);
        cpu_flag = 1'b0;
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_wf", int'(write_finished), 0);
        repeat (30) step();
        chk("abort_no_write", wr_count, w0);
        chk("abort_wf_late", int'(write_finished), 0);
    endtask

    task automatic run_reset_mid_capture();
        int a, c;
        step();
        trig_src    = 1'b0;
        trig_delay  = 16'd2;
        num_samples = (AW+1)'(20);
        cpu_flag    = 1'b1;
        a = cyc + 1;
        c = a + 1 + 2 + 1;
        push_writes(c, 8);
        wait_cyc(c + 7);
        chk("rst_pre_addr", int'(bram_addr), 7);
        rst      = 1'b1;
        cpu_flag = 1'b0;
        step();
        chk("rst_we", int'(bram_we), 0);
        chk("rst_addr", int'(bram_addr), 0);
        chk("rst_din", int'(bram_din), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wf", int'(write_finished), 0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            adc_mem[i] = (i < 256) ? (100 + i) : int'($urandom_range(0, (1 << DW) - 1));
        end
        rst         = 1'b1;
        cpu_flag    = 1'b0;
        ext_trig    = 1'b0;
        trig_src    = 1'b0;
        trig_delay  = 16'd0;
        num_samples = '0;
        adc_data    = '0;
        repeat (3) step();
        chk("reset_we", int'(bram_we), 0);
        chk("reset_addr", int'(bram_addr), 0);
        chk("reset_din", int'(bram_din), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wf", int'(write_finished), 0);
        rst = 1'b0;
        step();

        run_capture(0, 0, 4, 0, 0, 0, 0);
        run_capture(1, 5, 6, 10, 0, 0, 0);
        run_capture(1, 3, 5, 8, 1, 0, 0);
        run_capture(0, 0, 0, 0, 0, 0, 0);
        run_capture(0, 1, NMAX + 5, 0, 0, 0, 0);
        run_capture(0, 2, NMAX, 0, 0, 0, 1);
        run_abort(0);
        run_abort(1);
        run_capture(0, 4, 10, 0, 0, 1, 0);
        run_capture(0, 0, 3, 0, 0, 0, 4);
        run_reset_mid_capture();
        run_capture(0, 1, 10, 0, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            run_capture(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, NMAX + 6)), int'($urandom_range(1, 10)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)));
        end

        repeat (5) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
